// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for pipeline_ctrl: stall encodings, the ERET code and FSM states.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_SETTLE = 2'd2
  } state_e;

  localparam logic [5:0]  STALL_NONE = 6'b000000;
  localparam logic [5:0]  STALL_IF   = 6'b000011;
  localparam logic [5:0]  STALL_ID   = 6'b000111;
  localparam logic [5:0]  STALL_EX   = 6'b001111;
  localparam logic [5:0]  STALL_MEM  = 6'b011111;
  localparam logic [31:0] EXC_ERET   = 32'h0000_000e;

  // The deepest requesting stage wins; everything upstream of it is held too.
  function automatic logic [5:0] resolve_stall(input logic req_if, input logic req_id,
                                               input logic req_ex, input logic req_mem);
    logic [5:0] s;
    if (req_mem)     s = STALL_MEM;
    else if (req_ex) s = STALL_EX;
    else if (req_id) s = STALL_ID;
    else if (req_if) s = STALL_IF;
    else             s = STALL_NONE;
    return s;
  endfunction

endpackage

// File: rtl/stall_wdog.sv
// Stall watchdog: counts consecutive stalled cycles, saturates at LIMIT and
// raises a sticky timeout flag once LIMIT is reached.
module stall_wdog #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic stalled,
  input  logic flush,
  output logic timeout
);

  localparam int unsigned CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_next_s;
  logic          timeout_r;

  // next count: clear on any unstalled or flushing cycle, otherwise saturating increment
  always_comb begin
    cnt_next_s = cnt_r;
    if (!stalled || flush) begin
      cnt_next_s = {CW{1'b0}};
    end else if (cnt_r != LIMIT_C) begin
      cnt_next_s = cnt_r + CW'(1);
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // counter and sticky timeout registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r     <= {CW{1'b0}};
      timeout_r <= 1'b0;
    end else begin
      cnt_r <= cnt_next_s;
      if (stalled && !flush && (cnt_next_s == LIMIT_C)) begin
        timeout_r <= 1'b1;
      end else begin
        timeout_r <= timeout_r;
      end
    end
  end

  assign timeout = timeout_r;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller with exception redirect and stall watchdog.
// Optional performance counters are built when PIPELINE_PERF_EN is defined.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter int unsigned WDOG_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flush_count
);

  state_e      state_r;
  state_e      state_next_s;
  logic [5:0]  stall_s;
  logic        flush_s;
  logic [31:0] new_pc_s;

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // next state and zero-latency stall/flush/redirect outputs
  always_comb begin
    state_next_s = state_r;
    stall_s      = STALL_NONE;
    flush_s      = 1'b0;
    new_pc_s     = 32'h0000_0000;
    if (rst) begin
      state_next_s = ST_RUN;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (excepttype != 32'h0000_0000) begin
            flush_s      = 1'b1;
            new_pc_s     = (excepttype == EXC_ERET) ? cp0_epc : EXC_VECTOR;
            state_next_s = ST_FLUSH;
          end else begin
            stall_s      = resolve_stall(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
            state_next_s = ST_RUN;
          end
        end
        ST_FLUSH: begin
          state_next_s = ST_SETTLE;
        end
        ST_SETTLE: begin
          // exceptions seen here are dropped, not deferred
          stall_s      = resolve_stall(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
          state_next_s = ST_RUN;
        end
        default: begin
          state_next_s = ST_RUN;
        end
      endcase
    end
  end

  assign stall  = stall_s;
  assign flush  = flush_s;
  assign new_pc = new_pc_s;

  stall_wdog #(
    .LIMIT(WDOG_LIMIT)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .stalled(|stall_s),
    .flush  (flush_s),
    .timeout(stall_timeout)
  );

`ifdef PIPELINE_PERF_EN
  logic [31:0] perf_stall_r;
  logic [31:0] perf_flush_r;

  // free-running performance counters, wrapping modulo 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_r <= 32'd0;
      perf_flush_r <= 32'd0;
    end else begin
      perf_stall_r <= (|stall_s) ? perf_stall_r + 32'd1 : perf_stall_r;
      perf_flush_r <= flush_s ? perf_flush_r + 32'd1 : perf_flush_r;
    end
  end

  assign perf_stall_cycles = perf_stall_r;
  assign perf_flush_count  = perf_flush_r;
`else
  assign perf_stall_cycles = 32'd0;
  assign perf_flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized
// traffic, all compared each cycle against a behavioural model.
module tb_pipeline_ctrl;

  localparam int unsigned LIMIT = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallreq_if = 1'b0, stallreq_id = 1'b0, stallreq_ex = 1'b0, stallreq_mem = 1'b0;
  logic [31:0] excepttype = 32'd0;
  logic [31:0] cp0_epc = 32'd0;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
  logic [31:0] perf_stall_cycles, perf_flush_count;

  always #5 clk = ~clk;

  pipeline_ctrl #(.EXC_VECTOR(32'h0000_0020), .WDOG_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .excepttype(excepttype), .cp0_epc(cp0_epc),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .stall_timeout(stall_timeout),
    .perf_stall_cycles(perf_stall_cycles), .perf_flush_count(perf_flush_count)
  );

  int errors = 0;
  int checks = 0;

  // model: cycles elapsed since an accepted exception (0 = normal running)
  int          phase = 0;
  int unsigned wd = 0;
  bit          to = 1'b0;
  int unsigned ps = 0, pf = 0;
  bit          seeded = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // one clock cycle: drive inputs, compare at the falling edge, advance the model
  task automatic step(input logic r, input logic i, input logic d, input logic e,
                      input logic m, input logic [31:0] exc, input logic [31:0] epc);
    logic [5:0]  es;
    logic        ef;
    logic [31:0] ep;
    int          n;
    @(posedge clk);
    #1;
    rst = r; stallreq_if = i; stallreq_id = d; stallreq_ex = e; stallreq_mem = m;
    excepttype = exc; cp0_epc = epc;
    @(negedge clk);
    es = 6'd0; ef = 1'b0; ep = 32'd0;
    if (!r) begin
      if (phase == 0 && exc != 32'd0) begin
        ef = 1'b1;
        ep = (exc == 32'h0000_000e) ? epc : 32'h0000_0020;
      end else if (phase != 1) begin
        n  = m ? 5 : e ? 4 : d ? 3 : i ? 2 : 0;
        es = 6'((1 << n) - 1);
      end
    end
    chk("stall", 32'(stall), 32'(es));
    chk("flush", 32'(flush), 32'(ef));
    chk("new_pc", new_pc, ep);
    if (seeded) begin
      chk("stall_timeout", 32'(stall_timeout), 32'(to));
`ifdef PIPELINE_PERF_EN
      chk("perf_stall_cycles", perf_stall_cycles, ps);
      chk("perf_flush_count", perf_flush_count, pf);
`else
      chk("perf_stall_cycles", perf_stall_cycles, 32'd0);
      chk("perf_flush_count", perf_flush_count, 32'd0);
`endif
    end
    if (r) begin
      phase = 0; wd = 0; to = 1'b0; ps = 0; pf = 0; seeded = 1'b1;
    end else begin
      phase = ef ? 1 : (phase == 1) ? 2 : 0;
      if (es != 6'd0) begin
        if (wd < LIMIT) wd++;
        if (wd == LIMIT) to = 1'b1;
        ps++;
      end else begin
        wd = 0;
      end
      if (ef) pf++;
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    logic [31:0] exc_r;
    int          sel;
    bit          burst;

    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0008, 32'h1234_5678);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_000e, 32'hdead_beef);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_timeout", 32'(stall_timeout), 32'd0);

    // IF and EX together: EX wins, release clears immediately
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
    chk("if_ex_stall", 32'(stall), 32'h0000_000f);
    idle();
    chk("release_stall", 32'(stall), 32'd0);

    // exception beats MEM stall, then FLUSH, SETTLE, RUN
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0008, 32'd0);
    chk("exc_flush", 32'(flush), 32'd1);
    chk("exc_stall", 32'(stall), 32'd0);
    chk("exc_pc", new_pc, 32'h0000_0020);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
    chk("flush_phase_stall", 32'(stall), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
    chk("settle_stall", 32'(stall), 32'h0000_001f);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0003, 32'd0);
    chk("run_third_cycle", 32'(flush), 32'd1);
    idle();
    idle();

    // ERET redirects to EPC
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_000e, 32'hbfc0_0100);
    chk("eret_pc", new_pc, 32'hbfc0_0100);
    chk("eret_flush", 32'(flush), 32'd1);
    idle();

    // exception during SETTLE is dropped and does not queue
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0001, 32'd0);
    chk("settle_exc_ignored", 32'(flush), 32'd0);
    idle();
    chk("no_queued_exc", 32'(flush), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0005, 32'd0);
    chk("back_in_run", 32'(flush), 32'd1);
    idle();
    idle();

    // watchdog: 300 cycles of ID stall
    for (int k = 1; k <= 300; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
      if (k == 255) chk("wdog_before_limit", 32'(stall_timeout), 32'd0);
      if (k == 256) chk("wdog_at_limit", 32'(stall_timeout), 32'd1);
    end
    idle();
    idle();
    chk("wdog_sticky", 32'(stall_timeout), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    idle();
    chk("wdog_rst_clear", 32'(stall_timeout), 32'd0);

    // perf counters: 10 stalled cycles and 2 exceptions
    for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0008, 32'd0);
    idle();
    idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_000e, 32'h0000_4000);
    idle();
    idle();
`ifdef PIPELINE_PERF_EN
    chk("perf_stall_10", perf_stall_cycles, 32'd10);
    chk("perf_flush_2", perf_flush_count, 32'd2);
`else
    chk("perf_stall_off", perf_stall_cycles, 32'd0);
    chk("perf_flush_off", perf_flush_count, 32'd0);
`endif

    // randomized traffic in segments, some with long stall bursts
    for (int seg = 0; seg < 16; seg++) begin
      burst = ($urandom_range(0, 2) == 0);
      for (int c = 0; c < 200; c++) begin
        sel = int'($urandom_range(0, 11));
        exc_r = (sel == 0) ? 32'h0000_000e : (sel == 1) ? $urandom : 32'd0;
        if (burst) exc_r = 32'd0;
        step(($urandom_range(0, 299) == 0),
             ($urandom_range(0, 3) == 0),
             burst ? 1'b1 : ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 5) == 0),
             exc_r, $urandom);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter EXC_VECTOR, default 32'h0000_0020, the redirect PC for all non-ERET exceptions.
REQ-002 SHALL have parameter WDOG_LIMIT, default 255, the number of consecutive stalled cycles before timeout.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have ports stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, input, 1 bit each: stage stall requests.
REQ-006 SHALL have port excepttype, input, 32 bits: the exception code from MEM; 0 means none.
REQ-007 SHALL have port cp0_epc, input, 32 bits: the EPC value, used for ERET.
REQ-008 SHALL have port stall, output, 6 bits: bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB; 1 means hold.
REQ-009 SHALL have port flush, output, 1 bit: clears all pipeline registers at the next edge.
REQ-010 SHALL have port new_pc, output, 32 bits: the redirect target, valid while flush=1.
REQ-011 SHALL have port stall_timeout, output, 1 bit: sticky watchdog flag.
REQ-012 SHALL have ports perf_stall_cycles and perf_flush_count, output, 32 bits each: performance counters.

Function
REQ-013 SHALL implement an FSM with states RUN, FLUSH and SETTLE; reset state RUN.
REQ-014 In RUN with excepttype != 0, SHALL drive flush=1 and stall=0 in the same cycle (combinational) and go to FLUSH.
REQ-015 FLUSH SHALL last exactly one cycle with flush=0 and stall=0, then go to SETTLE.
REQ-016 SETTLE SHALL last one cycle, ignore excepttype, resolve stalls as in RUN, then return to RUN.
REQ-017 When excepttype==32'h0000_000e (ERET), new_pc SHALL equal cp0_epc; for any other nonzero code it SHALL equal EXC_VECTOR; otherwise new_pc SHALL be 0.
REQ-018 Exceptions SHALL take priority over any stall request in the same cycle.
REQ-019 Stall SHALL be resolved with zero latency and the highest stage winning: mem 6'b011111, else ex 6'b001111, else id 6'b000111, else if 6'b000011, else 6'b000000.
REQ-020 The watchdog counter SHALL increment each cycle with stall != 0 and clear on any cycle with stall == 0 or flush=1.
REQ-021 The watchdog counter SHALL saturate at WDOG_LIMIT.
REQ-022 On reaching WDOG_LIMIT, stall_timeout SHALL set and hold until rst.
REQ-023 A new nonzero excepttype arriving during FLUSH or SETTLE SHALL be ignored and SHALL NOT queue.

Reset
REQ-024 On rst=1 at a clock edge: state SHALL go to RUN and watchdog, stall_timeout and both perf counters SHALL clear to 0.
REQ-025 While rst=1, stall, flush and new_pc SHALL be 0 regardless of inputs.
REQ-026 Reset mid-FLUSH or mid-SETTLE SHALL abandon the sequence; the first post-reset cycle is RUN.

Configuration
REQ-027 With macro PIPELINE_PERF_EN defined, perf_stall_cycles SHALL count cycles with stall != 0, and perf_flush_count SHALL count flush=1 cycles; both wrap modulo 2^32.
REQ-028 Without PIPELINE_PERF_EN, both perf outputs SHALL be constant 0 and no counter flops SHALL exist.

Structure
REQ-029 The stall encodings, the ERET code 32'h0000_000e and the FSM state encodings SHALL live in the shared defines header.
REQ-030 The watchdog SHALL be the single sub-module, stall_wdog, with parameter LIMIT.

Verification
REQ-031 Assert stallreq_ex=1 and stallreq_if=1 together: stall=6'b001111 in the same cycle; deassert both: stall=0 the next cycle.
REQ-032 Apply excepttype=8 with stallreq_mem=1: flush=1, stall=0, new_pc=32'h20; then one FLUSH cycle and one SETTLE cycle; RUN in the 3rd cycle.
REQ-033 Apply excepttype=32'he with cp0_epc=32'hbfc0_0100: new_pc=32'hbfc0_0100 with flush=1.
REQ-034 Apply excepttype=1 during SETTLE: no flush, state returns to RUN.
REQ-035 Hold stallreq_id=1 for 300 cycles with WDOG_LIMIT=255: stall_timeout rises after cycle 255 and stays high after release; rst clears it.
REQ-036 With PIPELINE_PERF_EN defined, apply 10 stalled cycles and 2 exceptions: perf_stall_cycles=10, perf_flush_count=2; without the macro, both read 0.
